// File: rtl/concat_unpacker.sv
// concat_unpacker: accepts one {byte0..byteN-1, tag} word and replays a
// contiguous byte slice of it (first +: len) as a byte stream with its tag.
// Byte 0 is the most-significant byte of the word. Slices that run past the
// end of the word are clipped, and clipping raises a sticky error flag.
module concat_unpacker #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned BYTEW  = 8,
  parameter int unsigned TAGW   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:NBYTES*BYTEW+TAGW-1]  in_data,
  input  logic [$clog2(NBYTES)-1:0]     in_first,
  input  logic [$clog2(NBYTES):0]       in_len,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BYTEW-1:0]              out_byte,
  output logic [0:TAGW-1]               out_tag,
  output logic [$clog2(NBYTES)-1:0]     out_index,
  output logic                          out_last,
  output logic                          err_clip
);

  localparam int unsigned IW = $clog2(NBYTES);
  localparam int unsigned LW = $clog2(NBYTES) + 1;
  localparam int unsigned SW = LW + 1;
  localparam int unsigned DW = NBYTES * BYTEW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Byte lane select; out-of-range indices read as zero.
  function automatic logic [BYTEW-1:0] pick_byte(input logic [0:DW-1] w,
                                                 input logic [IW-1:0] i);
    logic [BYTEW-1:0] b;
    b = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (i == IW'(k)) b = w[k*BYTEW +: BYTEW];
    end
    return b;
  endfunction

  state_t           state_q, state_d;
  logic [0:DW-1]    buf_q, buf_d;
  logic [0:TAGW-1]  tag_q, tag_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    end_q, end_d;
  logic             err_q, err_d;

  logic             out_valid_q, out_valid_d;
  logic [BYTEW-1:0] out_byte_q, out_byte_d;
  logic [0:TAGW-1]  out_tag_q, out_tag_d;
  logic [IW-1:0]    out_index_q, out_index_d;
  logic             out_last_q, out_last_d;

  logic             in_ready_c;
  logic             accept_c;
  logic             load_c;
  logic [SW-1:0]    sum_c;
  logic             first_ok_c;
  logic             over_c;
  logic             clip_c;
  logic             empty_c;
  logic [IW-1:0]    end_c;

  // Ready when idle, or when the final byte of the current slice hands off.
  assign in_ready_c = !rst &&
                      ((state_q == IDLE) ||
                       ((state_q == EMIT) && out_ready && out_last_q));
  assign accept_c   = in_valid && in_ready_c;

  // Decode the offered slice: end index, clipping and empty detection.
  always_comb begin
    sum_c      = SW'(in_first) + SW'(in_len);
    first_ok_c = SW'(in_first) < SW'(NBYTES);
    over_c     = sum_c > SW'(NBYTES);
    clip_c     = over_c || !first_ok_c;
    empty_c    = (in_len == '0) || !first_ok_c;
    end_c      = over_c ? IW'(NBYTES - 1) : IW'(sum_c - SW'(1));
  end

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    end_d   = end_q;
    err_d   = err_q;
    load_c  = 1'b0;

    case (state_q)
      IDLE: begin
        load_c = accept_c;
      end
      EMIT: begin
        if (out_ready) begin
          if (!out_last_q) begin
            idx_d = idx_q + IW'(1);
          end else if (accept_c) begin
            load_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_c) begin
      buf_d   = in_data[0:DW-1];
      tag_d   = in_data[DW +: TAGW];
      idx_d   = in_first;
      end_d   = end_c;
      state_d = empty_c ? IDLE : EMIT;
      if (clip_c) err_d = 1'b1;
    end

    out_valid_d = (state_d == EMIT);
    out_byte_d  = pick_byte(buf_d, idx_d);
    out_tag_d   = tag_d;
    out_index_d = idx_d;
    out_last_d  = (state_d == EMIT) && (idx_d == end_d);
  end

  // State, word buffer and output registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      tag_q       <= '0;
      idx_q       <= '0;
      end_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_tag_q   <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      end_q       <= end_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_tag_q   <= out_tag_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_tag   = out_tag_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign err_clip  = err_q;

endmodule

// File: tb/tb_concat_unpacker.sv
// Directed bench for concat_unpacker: full word, slice, clip, backpressure,
// back-to-back words, zero-length absorption and asynchronous reset.
module tb_concat_unpacker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:35] in_data;
  logic [1:0]  in_first;
  logic [2:0]  in_len;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic [0:3]  out_tag;
  logic [1:0]  out_index;
  logic        out_last;
  logic        err_clip;

  int tests;
  int fails;

  logic [7:0] bp_exp [4];
  int         pos;

  localparam logic [35:0] W1 = 36'hA1B2C3D45;
  localparam logic [35:0] W2 = 36'h11223344A;
  localparam logic [35:0] WZ = 36'hFFFFFFFF0;

  concat_unpacker #(
    .NBYTES(4),
    .BYTEW (8),
    .TAGW  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_first (in_first),
    .in_len   (in_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_tag  (out_tag),
    .out_index(out_index),
    .out_last (out_last),
    .err_clip (err_clip)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and check it is taken on the next edge.
  task automatic send(input string name, input logic [35:0] d,
                      input logic [1:0] f, input logic [2:0] l);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_len   = l;
    @(negedge clk);
    chk({name, ".in_ready"}, 64'(in_ready), 64'(1));
    adv();
    in_valid = 1'b0;
  endtask

  // Check one emitted byte with out_ready high; in_ready follows out_last.
  task automatic exp_byte(input string name, input logic [7:0] b, input logic [1:0] ix,
                          input logic [3:0] tg, input logic last, input logic ec);
    @(negedge clk);
    chk({name, ".valid"}, 64'(out_valid), 64'(1));
    chk({name, ".byte"},  64'(out_byte),  64'(b));
    chk({name, ".index"}, 64'(out_index), 64'(ix));
    chk({name, ".tag"},   64'(out_tag),   64'(tg));
    chk({name, ".last"},  64'(out_last),  64'(last));
    chk({name, ".ready"}, 64'(in_ready),  64'(last));
    chk({name, ".err"},   64'(err_clip),  64'(ec));
    adv();
  endtask

  task automatic exp_idle(input string name);
    @(negedge clk);
    chk({name, ".valid"}, 64'(out_valid), 64'(0));
    chk({name, ".ready"}, 64'(in_ready),  64'(1));
    adv();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_first  = '0;
    in_len    = '0;
    out_ready = 1'b0;
    bp_exp[0] = 8'hA1;
    bp_exp[1] = 8'hB2;
    bp_exp[2] = 8'hC3;
    bp_exp[3] = 8'hD4;

    // Reset values
    @(negedge clk);
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.byte",  64'(out_byte),  64'(0));
    chk("rst.tag",   64'(out_tag),   64'(0));
    chk("rst.index", 64'(out_index), 64'(0));
    chk("rst.last",  64'(out_last),  64'(0));
    chk("rst.err",   64'(err_clip),  64'(0));
    chk("rst.ready", 64'(in_ready),  64'(0));
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("rel.ready", 64'(in_ready), 64'(1));
    adv();

    // Full word
    out_ready = 1'b1;
    send("full", W1, 2'd0, 3'd4);
    exp_byte("full0", 8'hA1, 2'd0, 4'h5, 1'b0, 1'b0);
    exp_byte("full1", 8'hB2, 2'd1, 4'h5, 1'b0, 1'b0);
    exp_byte("full2", 8'hC3, 2'd2, 4'h5, 1'b0, 1'b0);
    exp_byte("full3", 8'hD4, 2'd3, 4'h5, 1'b1, 1'b0);
    exp_idle("full.end");

    // Slice first=1 len=2
    send("slice", W1, 2'd1, 3'd2);
    exp_byte("slice0", 8'hB2, 2'd1, 4'h5, 1'b0, 1'b0);
    exp_byte("slice1", 8'hC3, 2'd2, 4'h5, 1'b1, 1'b0);
    exp_idle("slice.end");

    // Clip first=2 len=3
    send("clip", W1, 2'd2, 3'd3);
    exp_byte("clip0", 8'hC3, 2'd2, 4'h5, 1'b0, 1'b1);
    exp_byte("clip1", 8'hD4, 2'd3, 4'h5, 1'b1, 1'b1);
    exp_idle("clip.end");

    // Backpressure: out_ready high on every third cycle
    send("bp", W1, 2'd0, 3'd4);
    pos = 0;
    for (int k = 0; k < 20 && pos < 4; k++) begin
      out_ready = ((k % 3) == 0);
      @(negedge clk);
      chk("bp.valid", 64'(out_valid), 64'(1));
      chk("bp.byte",  64'(out_byte),  64'(bp_exp[pos]));
      chk("bp.index", 64'(out_index), 64'(pos));
      chk("bp.last",  64'(out_last),  64'(pos == 3));
      chk("bp.ready", 64'(in_ready),  64'(out_ready && (pos == 3)));
      chk("bp.err",   64'(err_clip),  64'(1));
      adv();
      if (out_ready) pos++;
    end
    chk("bp.count", 64'(pos), 64'(4));
    out_ready = 1'b1;
    exp_idle("bp.end");

    // Back-to-back: W2 waits with in_valid held and is taken on the D4 handshake
    in_valid = 1'b1;
    in_data  = W1;
    in_first = 2'd0;
    in_len   = 3'd4;
    @(negedge clk);
    chk("b2b.acc1", 64'(in_ready), 64'(1));
    adv();
    in_data  = W2;
    exp_byte("b2b.a0", 8'hA1, 2'd0, 4'h5, 1'b0, 1'b1);
    exp_byte("b2b.a1", 8'hB2, 2'd1, 4'h5, 1'b0, 1'b1);
    exp_byte("b2b.a2", 8'hC3, 2'd2, 4'h5, 1'b0, 1'b1);
    exp_byte("b2b.a3", 8'hD4, 2'd3, 4'h5, 1'b1, 1'b1);
    in_data  = WZ;
    in_len   = 3'd0;
    exp_byte("b2b.b0", 8'h11, 2'd0, 4'hA, 1'b0, 1'b1);
    exp_byte("b2b.b1", 8'h22, 2'd1, 4'hA, 1'b0, 1'b1);
    exp_byte("b2b.b2", 8'h33, 2'd2, 4'hA, 1'b0, 1'b1);
    exp_byte("b2b.b3", 8'h44, 2'd3, 4'hA, 1'b1, 1'b1);
    // Zero-length word absorbed on the 44 handshake; next word waits in IDLE
    in_data  = W1;
    in_first = 2'd3;
    in_len   = 3'd1;
    exp_idle("b2b.zero");
    in_valid = 1'b0;
    exp_byte("b2b.c0", 8'hD4, 2'd3, 4'h5, 1'b1, 1'b1);
    exp_idle("b2b.end");

    // Asynchronous reset during C3
    send("rstw", W1, 2'd0, 3'd4);
    exp_byte("rstw0", 8'hA1, 2'd0, 4'h5, 1'b0, 1'b1);
    exp_byte("rstw1", 8'hB2, 2'd1, 4'h5, 1'b0, 1'b1);
    @(negedge clk);
    chk("rstw2.byte", 64'(out_byte), 64'(8'hC3));
    #1;
    rst = 1'b1;
    #1;
    chk("arst.valid", 64'(out_valid), 64'(0));
    chk("arst.byte",  64'(out_byte),  64'(0));
    chk("arst.tag",   64'(out_tag),   64'(0));
    chk("arst.index", 64'(out_index), 64'(0));
    chk("arst.last",  64'(out_last),  64'(0));
    chk("arst.err",   64'(err_clip),  64'(0));
    chk("arst.ready", 64'(in_ready),  64'(0));
    adv();
    @(negedge clk);
    chk("arst.hold.ready", 64'(in_ready), 64'(0));
    chk("arst.hold.valid", 64'(out_valid), 64'(0));
    adv();
    rst = 1'b0;
    exp_idle("arst.rel");
    send("post", W1, 2'd1, 3'd3);
    exp_byte("post0", 8'hB2, 2'd1, 4'h5, 1'b0, 1'b0);
    exp_byte("post1", 8'hC3, 2'd2, 4'h5, 1'b0, 1'b0);
    exp_byte("post2", 8'hD4, 2'd3, 4'h5, 1'b1, 1'b0);
    exp_idle("post.end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/concat_unpacker.md
# concat_unpacker

Sequential unpacker that accepts one concatenated word {a, b} and replays it as a byte stream with its tag. The word is NBYTES packed bytes of BYTEW bits, most-significant byte first, followed by a TAGW-bit tag in the least-significant bits. It is the receive-side counterpart of the packed-array concatenation logic in the analysis testcases. It sits between a word-wide producer and a byte-wide consumer, and supports emitting a contiguous byte slice (first +: len) instead of the whole word.

## Interface
- NBYTES, 4, number of packed bytes per word (>= 2)
- BYTEW, 8, bits per byte
- TAGW, 4, tag width (b field)
- IW, $clog2(NBYTES), index width; LW, $clog2(NBYTES)+1, length width (derived, not overridable)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  word offered
- in_ready  output  1  word accepted when in_valid && in_ready
- in_data  input  [0:NBYTES*BYTEW+TAGW-1]  {byte0..byteN-1, tag}; byte0 = in_data[0:BYTEW-1]
- in_first  input  IW  index of first byte to emit
- in_len  input  LW  number of bytes to emit
- out_valid  output  1  byte available
- out_ready  input  1  consumer accepts byte when out_valid && out_ready
- out_byte  output  [BYTEW-1:0]  current byte
- out_tag  output  [0:TAGW-1]  tag of the word being emitted, constant across its bytes
- out_index  output  IW  byte index within the word
- out_last  output  1  high on the final byte of the slice
- err_clip  output  1  sticky; set when a slice was clipped, cleared only by rst

## Operation
- States: IDLE and EMIT. A word buffer, a tag register, an index register idx and an end register are held.
- IDLE:
  - in_ready = 1.
  - On accept, store data, tag and first; compute end = min(first+len, NBYTES) - 1.
  - If first+len > NBYTES, set err_clip.
  - If len == 0, or the effective length is 0, the word is consumed, nothing is emitted, and the block stays in IDLE.
  - Otherwise go to EMIT with idx = first.
- EMIT:
  - out_valid = 1; out_byte = buffer byte idx; out_index = idx; out_last = (idx == end).
  - On an output handshake with !out_last: idx += 1.
  - On an output handshake with out_last: the word is done. in_ready = 1 in that same cycle (back-to-back).
    - If a new word is accepted, reload per the IDLE rules and stay in EMIT (or go to IDLE if its length is 0).
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==EMIT && out_ready && out_last). in_ready is forced 0 while rst is asserted.
- Outputs hold stable while out_valid && !out_ready (no byte is dropped or changed).
- Byte order follows packed [0:N-1][BYTEW-1:0] semantics: index 0 is the MSB byte of the word.
- Arithmetic for first+len uses LW+1 bits, so it never wraps. in_first >= NBYTES (non-power-of-2 NBYTES) is treated as clipped: nothing is emitted and err_clip is set.

## Timing
- Reset values: state IDLE, out_valid 0, out_last 0, out_byte 0, out_tag 0, out_index 0, err_clip 0, buffer 0. Reset mid-EMIT discards the word immediately, asynchronously.
- Latency: the first byte is on the outputs the cycle after word acceptance.
- Throughput: 1 byte/cycle with out_ready held high. A full word of NBYTES bytes plus the next word sustains 100% output duty (no bubble between words).
- out_* are driven only from registers; there is no combinational path from in_data to out_*. in_ready does depend combinationally on out_ready.
- A zero-length word costs one accept cycle and produces no output.

## Test plan
- Full word: in_data={8'hA1,8'hB2,8'hC3,8'hD4,4'h5}, first=0, len=4, out_ready=1. Required: bytes A1,B2,C3,D4 on 4 consecutive cycles; index 0..3; tag 5 throughout; out_last only on D4; err_clip stays 0.
- Slice: same word, first=1, len=2. Required: B2 then C3, out_last on C3; then IDLE.
- Clip: first=2, len=3. Required: C3, D4 (last); err_clip=1 and it stays set through later words until rst.
- Backpressure: out_ready toggling 1,0,0,1,... on a full word. Required: each byte is held unchanged while stalled, and the sequence A1..D4 completes with no loss or duplication.
- Back-to-back: second word {11,22,33,44,tag A} is presented with in_valid held during the first word. Required: it is accepted in the cycle D4 handshakes, and 11 follows D4 with no idle cycle. A zero-length word in between is absorbed with no output.
- Reset: assert rst during byte C3. Required: out_valid=0 asynchronously, all outputs at reset values, in_ready=0 during rst and 1 after release; the next word emits from its own first index.
